// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the instruction-fetch stage
package fetch_unit_pkg;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    // Instruction word that stops fetch when FETCH_HALT_EN is defined.
    localparam logic [31:0] HALT_WORD = 32'h0000_0000;

    // Value loaded into the IF/ID instruction field when a bubble is inserted.
    localparam logic [31:0] BUBBLE = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - program counter register with redirect/advance next-PC mux
module fetch_pc_gen #(
    parameter int                  REGSIZE  = 32,
    parameter logic [REGSIZE-1:0]  RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic               advance,
    input  logic [REGSIZE-1:0] target,
    output logic [REGSIZE-1:0] pc
);

    logic [REGSIZE-1:0] pc_next;

    // Redirect wins over sequential advance; word-address increment wraps at all-ones.
    always_comb begin
        pc_next = pc;
        if (load) begin
            pc_next = target;
        end else if (advance) begin
            pc_next = pc + REGSIZE'(1);
        end
    end

    // PC register; asynchronous reset returns fetch to RESET_PC.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch stage with IF/ID register, stall, redirect and optional FETCH_HALT_EN halt-on-zero-word
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                  BITSIZE  = 32,
    parameter int                  REGSIZE  = 32,
    parameter logic [REGSIZE-1:0]  RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [REGSIZE-1:0] branch_target,
    output logic [REGSIZE-1:0] imem_addr,
    input  logic [BITSIZE-1:0] imem_data,
    output logic [BITSIZE-1:0] if_instr,
    output logic [REGSIZE-1:0] if_pc,
    output logic               if_valid,
    output logic               halted
);

    fetch_state_t       state;
    logic [REGSIZE-1:0] pc;
    logic               zero_fetch;
    logic               pc_advance;
    logic               halted_q;

    // A zero word stops fetch only in the halt-enabled build.
`ifdef FETCH_HALT_EN
    assign zero_fetch = (imem_data == BITSIZE'(HALT_WORD));
`else
    assign zero_fetch = 1'b0;
`endif

    // PC moves forward only on a real issue in RUN; redirect is handled by load.
    assign pc_advance = (state == RUN) && !branch_taken && !stall && !zero_fetch;

    fetch_pc_gen #(
        .REGSIZE  (REGSIZE),
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (branch_taken),
        .advance (pc_advance),
        .target  (branch_target),
        .pc      (pc)
    );

    assign imem_addr = pc;
    assign halted    = halted_q;

    // Fetch state machine and IF/ID pipeline register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= RUN;
            if_instr <= '0;
            if_pc    <= '0;
            if_valid <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (branch_taken) begin
                        if_instr <= BITSIZE'(BUBBLE);
                        if_valid <= 1'b0;
                    end else if (stall) begin
                        // hold IF/ID contents
                    end else if (zero_fetch) begin
                        if_valid <= 1'b0;
                        halted_q <= 1'b1;
                        state    <= HALT;
                    end else begin
                        if_instr <= imem_data;
                        if_pc    <= pc;
                        if_valid <= 1'b1;
                    end
                end
                HALT: begin
                    if_valid <= 1'b0;
                    if (branch_taken) begin
                        if_instr <= BITSIZE'(BUBBLE);
                        halted_q <= 1'b0;
                        state    <= RUN;
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard testbench for fetch_unit (build with or without FETCH_HALT_EN)
module tb_fetch_unit;

`ifdef FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic [31:0] addr;
        logic        halted;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        halted;

    logic [31:0] mem [0:31];

    int n_checks = 0;
    int n_pass   = 0;

    exp_t sb[$];

    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic        m_valid;
    logic        m_halted;
    logic        m_in_halt;

    fetch_unit #(
        .BITSIZE  (32),
        .REGSIZE  (32),
        .RESET_PC (32'd0)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .if_valid      (if_valid),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr[4:0]];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc      = 32'd0;
        m_instr   = 32'd0;
        m_ipc     = 32'd0;
        m_valid   = 1'b0;
        m_halted  = 1'b0;
        m_in_halt = 1'b0;
        sb.delete();
    endtask

    // Advance the reference model by one edge given the inputs about to be sampled.
    task automatic model_edge(input logic s, input logic b, input logic [31:0] t);
        logic [31:0] w;
        w = mem[m_pc[4:0]];
        if (b) begin
            m_pc      = t;
            m_valid   = 1'b0;
            m_instr   = 32'd0;
            m_in_halt = 1'b0;
            m_halted  = 1'b0;
        end else if (m_in_halt) begin
            m_valid = 1'b0;
        end else if (s) begin
            // hold
        end else if (HALT_EN && (w == 32'd0)) begin
            m_valid   = 1'b0;
            m_in_halt = 1'b1;
            m_halted  = 1'b1;
        end else begin
            m_instr = w;
            m_ipc   = m_pc;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd1;
        end
    endtask

    task automatic step(input logic s, input logic b, input logic [31:0] t);
        exp_t e;
        stall         = s;
        branch_taken  = b;
        branch_target = t;
        model_edge(s, b, t);
        e.instr  = m_instr;
        e.pc     = m_ipc;
        e.valid  = m_valid;
        e.addr   = m_pc;
        e.halted = m_halted;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("if_instr",  if_instr,        e.instr);
        check("if_pc",     if_pc,           e.pc);
        check("if_valid",  32'(if_valid),   32'(e.valid));
        check("imem_addr", imem_addr,       e.addr);
        check("halted",    32'(halted),     32'(e.halted));
        @(negedge clk);
        stall        = 1'b0;
        branch_taken = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},   imem_addr,      32'd0);
        check({tag, "_instr"},  if_instr,       32'd0);
        check({tag, "_pc"},     if_pc,          32'd0);
        check({tag, "_valid"},  32'(if_valid),  32'd0);
        check({tag, "_halted"}, 32'(halted),    32'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i] = 32'h0000_0013 | (32'(i) << 7);
        end
        mem[0]  = 32'h0000_7033;
        mem[1]  = 32'h0010_0093;
        mem[2]  = 32'h0020_0113;
        mem[14] = 32'h0000_02b7;
        mem[20] = 32'h0000_0000;

        reset_n       = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'd0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // Reset release: words 0 and 1 in order.
        step(1'b0, 1'b0, 32'd0);
        check("tp_edge1_instr", if_instr, 32'h0000_7033);
        step(1'b0, 1'b0, 32'd0);
        check("tp_edge2_instr", if_instr, 32'h0010_0093);
        check("tp_edge2_pc",    if_pc,    32'd1);
        step(1'b0, 1'b0, 32'd0);

        // Stall three cycles while if_pc = 2.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'd0);
            check("tp_stall_instr", if_instr,  32'h0020_0113);
            check("tp_stall_addr",  imem_addr, 32'd3);
        end
        step(1'b0, 1'b0, 32'd0);
        check("tp_resume_pc", if_pc, 32'd3);

        // Branch while stalled: one bubble, then target.
        step(1'b1, 1'b1, 32'd14);
        check("tp_br_valid", 32'(if_valid), 32'd0);
        check("tp_br_addr",  imem_addr,     32'd14);
        step(1'b0, 1'b0, 32'd0);
        check("tp_br_instr", if_instr, 32'h0000_02b7);
        check("tp_br_pc",    if_pc,    32'd14);

        // Run through word 19 and into the zero word at 20.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'd0);
        check("tp_pc19", if_pc, 32'd19);
        step(1'b0, 1'b0, 32'd0);
`ifdef FETCH_HALT_EN
        check("tp_halt_flag",  32'(halted),   32'd1);
        check("tp_halt_valid", 32'(if_valid), 32'd0);
        check("tp_halt_addr",  imem_addr,     32'd20);
        step(1'b0, 1'b0, 32'd0);
        check("tp_halt_hold",  imem_addr,     32'd20);
`else
        check("tp_zero_valid", 32'(if_valid), 32'd1);
        check("tp_zero_pc",    if_pc,         32'd20);
        check("tp_zero_instr", if_instr,      32'd0);
`endif
        step(1'b0, 1'b1, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        check("tp_restart_instr", if_instr, 32'h0000_7033);

        // Wrap from all-ones to zero.
        step(1'b0, 1'b1, 32'hFFFF_FFFF);
        step(1'b0, 1'b0, 32'd0);
        check("tp_wrap_addr", imem_addr, 32'd0);
        check("tp_wrap_pc",   if_pc,     32'hFFFF_FFFF);

        // Randomised mix of stall / redirect against the scoreboard.
        for (int i = 0; i < 60; i++) begin
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0),
                 32'($urandom_range(0, 31)));
        end

        // Mid-run asynchronous reset, observed before the next edge.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b0, 1'b0, 32'd0);
        check("post_reset_pc",    if_pc,    32'd0);
        check("post_reset_instr", if_instr, 32'h0000_7033);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the lab CPU. Holds the program counter, drives the word address into the combinational instruction memory, and registers the returned instruction with its PC into an IF/ID pipeline register consumed by decode. Supports stall, branch/jump redirect with bubble insertion, and an optional halt-on-zero-word feature.

## Interface
- `BITSIZE`, 32, instruction width.
- `REGSIZE`, 32, PC/address width.
- `RESET_PC`, 0, word address fetched first after reset.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  decode back-pressure; hold PC and IF/ID register.
- `branch_taken`  in  1  redirect request from execute.
- `branch_target`  in  REGSIZE  word address to redirect to.
- `imem_addr`  out  REGSIZE  word address to instruction memory (equals PC).
- `imem_data`  in  BITSIZE  instruction word, combinational from memory.
- `if_instr`  out  BITSIZE  registered instruction.
- `if_pc`  out  REGSIZE  word address of `if_instr`.
- `if_valid`  out  1  `if_instr`/`if_pc` hold a real instruction.
- `halted`  out  1  fetch stopped (only with `FETCH_HALT_EN`).

## Operation
- PC is a word address; sequential increment is +1, not +4. Arithmetic is modulo 2^REGSIZE; PC all-ones wraps to 0.
- `imem_addr` is driven directly from the PC register (no extra logic in the path).
- States: `RUN`, `HALT`. Reset enters `RUN`.
- Per-edge priority in `RUN`:
  1. `branch_taken`: PC <= `branch_target`; `if_valid` <= 0; `if_instr` <= 0; `if_pc` unchanged. Overrides `stall`.
  2. `stall`: PC, `if_instr`, `if_pc`, `if_valid` all hold.
  3. Otherwise: `if_instr` <= `imem_data`; `if_pc` <= PC; `if_valid` <= 1; PC <= PC+1.
- `HALT`: PC and IF/ID hold except `if_valid` <= 0; `branch_taken` still redirects PC and returns to `RUN`; otherwise remains until reset.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous); in-flight instruction is discarded.

## Timing
- Reset values: PC = `imem_addr` = `RESET_PC`; `if_instr` = 0; `if_pc` = 0; `if_valid` = 0; `halted` = 0; state `RUN`.
- Latency: instruction at PC appears on `if_instr` one edge after PC is presented. First edge after `reset_n` rises yields `if_pc` = `RESET_PC`, `if_valid` = 1.
- Branch penalty: exactly one bubble (`if_valid` = 0 for one cycle); target instruction valid on the second edge after `branch_taken` is sampled.
- Stall is level-sensitive; N stalled cycles extend the current IF/ID contents by N cycles with no loss or duplication.
- Throughput: one instruction per cycle when unstalled.

## Configuration
- `FETCH_HALT_EN` defined: when a fetch (rule 3) captures `imem_data` == 0, the zero word is not issued (`if_valid` <= 0), PC holds, state goes to `HALT`, `halted` <= 1. `halted` clears on branch redirect.
- Undefined: zero words are fetched and issued like any instruction; `HALT` state unreachable; `halted` tied 0.

## Structure
- Shared package: state enum (`RUN`, `HALT`), `HALT_WORD` constant (32'h0), bubble constant (32'h0).
- One sub-module natural: `fetch_pc_gen` (PC register, next-PC mux, wrap). IF/ID register and state machine stay in `fetch_unit`.

## Test plan
- Reset release with memory preloaded (word0 = 0x00007033, word1 = 0x00100093) -> edge 1: `if_instr` = 0x00007033, `if_pc` = 0, `if_valid` = 1; edge 2: 0x00100093, `if_pc` = 1.
- `stall` high 3 cycles while `if_pc` = 2 -> `if_instr` holds 0x00200113, `imem_addr` holds 3; resume yields `if_pc` = 3 next edge, no skip.
- `branch_taken` = 1, `branch_target` = 14 while stalled -> next edge `if_valid` = 0, `imem_addr` = 14; following edge `if_instr` = 0x000002b7, `if_pc` = 14.
- PC preset via branch to 32'hFFFFFFFF -> after one fetch, `imem_addr` = 0.
- With `FETCH_HALT_EN`, run past word 19 (word 20 = 0) -> `halted` = 1, `if_valid` = 0, `imem_addr` stays 20; branch to 0 restarts and fetches 0x00007033. Without macro: word 20 issued, `if_valid` = 1.
- Assert `reset_n` low between edges mid-run -> outputs at reset values immediately, before next clock edge.
